cpu_io_responder: RTL and testbench

//  Peripheral-side endpoint of the CPU I/O interface: feeds the core's data_in, raises its interrupt, captures data_out.

---
 rtl/cpu_io_responder.sv | 114 +++++++++++
 tb/tb_cpu_io_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_responder.sv
// cpu_io_responder: CPU I/O endpoint with input FIFO, interrupt FSM and output holding register.
// Optional IOR_WATERMARK_EN: interrupt on fill >= WATERMARK, or when a partial batch ages 16 cycles.
module cpu_io_responder #(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int INT_HOLDOFF = 4,
    parameter int WATERMARK   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ext_in_valid,
    output logic          ext_in_ready,
    input  logic [15:0]   ext_in_data,
    output logic [15:0]   data_in,
    output logic          interrupt,
    input  logic          int_ack,
    input  logic          rd_pop,
    input  logic [15:0]   data_out,
    input  logic          wr_stb,
    output logic          ext_out_valid,
    input  logic          ext_out_ready,
    output logic [15:0]   ext_out_data,
    output logic [AW:0]   fifo_count,
    output logic          out_overrun
);
    localparam int HW = (INT_HOLDOFF > 1) ? $clog2(INT_HOLDOFF) : 1;
    typedef enum logic [1:0] {IDLE, REQ, SERVICE, HOLDOFF} state_t;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop, trigger;
    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          int_q, int_d;
    logic          out_valid_q, out_valid_d, overrun_q, overrun_d;
    logic [15:0]   out_data_q, out_data_d;
    assign ext_in_ready  = count_q < (AW+1)'(DEPTH);
    assign data_in       = (count_q != '0) ? mem_q[rd_ptr_q] : 16'h0000;
    assign interrupt     = int_q;
    assign ext_out_valid = out_valid_q;
    assign ext_out_data  = out_data_q;
    assign fifo_count    = count_q;
    assign out_overrun   = overrun_q;
    always_comb begin
        push     = ext_in_valid && ext_in_ready;
        pop      = rd_pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= ext_in_data;
    end
`ifdef IOR_WATERMARK_EN
    logic [3:0] age_q, age_d;
    // Age tracks how long a non-empty FIFO has waited below the watermark.
    assign age_d   = (state_q == IDLE && count_q != '0) ? age_q + 4'd1 : 4'd0;
    assign trigger = (count_q >= (AW+1)'(WATERMARK)) || (count_q != '0 && age_q == 4'd15);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            age_q <= 4'd0;
        else
            age_q <= age_d;
    end
`else
    assign trigger = count_q != '0;
`endif
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE:    state_d = trigger ? REQ : IDLE;
            REQ:     state_d = int_ack ? SERVICE : REQ;
            SERVICE: begin
                state_d = pop ? HOLDOFF : SERVICE;
                hold_d  = '0;
            end
            HOLDOFF: begin
                state_d = (hold_q == HW'(INT_HOLDOFF - 1)) ? IDLE : HOLDOFF;
                hold_d  = hold_q + 1'b1;
            end
        endcase
        int_d = state_d == REQ;
    end
    always_comb begin
        out_valid_d = wr_stb || (out_valid_q && !ext_out_ready);
        out_data_d  = (wr_stb && (!out_valid_q || ext_out_ready)) ? data_out : out_data_q;
        overrun_d   = overrun_q || (wr_stb && out_valid_q && !ext_out_ready);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            hold_q      <= '0;
            int_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            int_q       <= int_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
        end
    end
endmodule

// File: tb/tb_cpu_io_responder.sv
// tb_cpu_io_responder: directed and randomized bench with a queue-based FIFO and output-register model.
module tb_cpu_io_responder;
    logic        clk = 0, reset = 1;
    logic        ext_in_valid = 0, int_ack = 0, rd_pop = 0, wr_stb = 0, ext_out_ready = 0;
    logic [15:0] ext_in_data = 0, data_out = 0;
    logic        ext_in_ready, interrupt, ext_out_valid, out_overrun;
    logic [15:0] data_in, ext_out_data;
    logic [3:0]  fifo_count;
    int          checks = 0, errors = 0;
    logic [15:0] q[$];
    logic        m_ov, m_oo;
    logic [15:0] m_od;

    cpu_io_responder dut (
        .clk(clk), .reset(reset), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
        .ext_in_data(ext_in_data), .data_in(data_in), .interrupt(interrupt), .int_ack(int_ack),
        .rd_pop(rd_pop), .data_out(data_out), .wr_stb(wr_stb), .ext_out_valid(ext_out_valid),
        .ext_out_ready(ext_out_ready), .ext_out_data(ext_out_data), .fifo_count(fifo_count),
        .out_overrun(out_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] head();
        return (q.size() > 0) ? q[0] : 16'h0000;
    endfunction

    task automatic clear_model();
        q.delete();
        m_ov = 0; m_oo = 0; m_od = 0;
    endtask

    task automatic drive_cycle(input bit v, input logic [15:0] d, input bit p, input bit ack,
                               input bit ws, input logic [15:0] dw, input bit rdy);
        bit do_push, do_pop;
        ext_in_valid = v; ext_in_data = d; rd_pop = p; int_ack = ack;
        wr_stb = ws; data_out = dw; ext_out_ready = rdy;
        do_push = v && q.size() < 8;
        do_pop  = p && q.size() > 0;
        @(posedge clk); #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(d);
        if (ws) begin
            if (!m_ov || rdy) begin m_od = dw; m_ov = 1; end
            else m_oo = 1;
        end else if (m_ov && rdy) m_ov = 0;
        ext_in_valid = 0; rd_pop = 0; int_ack = 0; wr_stb = 0; ext_out_ready = 0;
    endtask

    task automatic do_reset();
        #1 reset = 0;
        clear_model();
        @(posedge clk);
        @(negedge clk) reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ext_in_ready !== 1'b1 || fifo_count !== 4'd0 || interrupt !== 1'b0) begin errors++; $display("FAIL reset_init: ready=%b count=%0d int=%b", ext_in_ready, fifo_count, interrupt); end
        for (int i = 0; i < 3; i++) drive_cycle(1, 16'h0100 + 16'(i), 0, 0, i < 2, 16'h55A0 + 16'(i), 0);
        checks++; if (fifo_count !== 4'd3 || out_overrun !== 1'b1 || ext_out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset: count=%0d ovr=%b valid=%b exp 3 1 1", fifo_count, out_overrun, ext_out_valid); end
        #2 reset = 0;
        #1;
        clear_model();
        checks++; if (ext_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", ext_in_ready); end
        checks++; if (data_in !== 16'h0) begin errors++; $display("FAIL rst_data_in: got %h exp 0000", data_in); end
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_interrupt: got %b exp 0", interrupt); end
        checks++; if (ext_out_valid !== 1'b0 || ext_out_data !== 16'h0) begin errors++; $display("FAIL rst_out: valid=%b data=%h exp 0 0000", ext_out_valid, ext_out_data); end
        checks++; if (fifo_count !== 4'd0 || out_overrun !== 1'b0) begin errors++; $display("FAIL rst_count_ovr: count=%0d ovr=%b exp 0 0", fifo_count, out_overrun); end
        @(negedge clk) reset = 1;
        @(posedge clk); #1;
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rst_release_count: got %0d exp 0", fifo_count); end
    endtask

    task automatic test_fill();
        logic [15:0] exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            checks++; if (ext_in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b exp 1", i, ext_in_ready); end
            drive_cycle(1, 16'hA000 + 16'(i), 0, 0, 0, 0, 0);
            checks++; if (fifo_count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count%0d: got %0d exp %0d", i, fifo_count, i + 1); end
        end
        checks++; if (ext_in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", ext_in_ready); end
        drive_cycle(1, 16'hA0FF, 0, 0, 0, 0, 0);
        checks++; if (fifo_count !== 4'd8 || data_in !== 16'hA000) begin errors++; $display("FAIL ninth_push: count=%0d head=%h exp 8 A000", fifo_count, data_in); end
        for (int i = 0; i < 8; i++) begin
            exp = 16'hA000 + 16'(i);
            checks++; if (data_in !== exp) begin errors++; $display("FAIL fill_order%0d: got %h exp %h", i, data_in, exp); end
            drive_cycle(0, 0, 1, 0, 0, 0, 0);
        end
        checks++; if (data_in !== 16'h0 || fifo_count !== 4'd0) begin errors++; $display("FAIL drained: head=%h count=%0d exp 0000 0", data_in, fifo_count); end
        drive_cycle(0, 0, 1, 0, 0, 0, 0);
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL pop_empty: got %0d exp 0", fifo_count); end
    endtask

    task automatic test_interrupt();
        do_reset();
        drive_cycle(1, 16'h1234, 0, 0, 0, 0, 0);
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL int_early: got %b exp 0", interrupt); end
        drive_cycle(1, 16'h1235, 0, 0, 0, 0, 0);
        checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL int_raise: got %b exp 1", interrupt); end
        drive_cycle(0, 0, 1, 0, 0, 0, 0);
        checks++; if (interrupt !== 1'b1 || data_in !== 16'h1235) begin errors++; $display("FAIL pop_in_req: int=%b head=%h exp 1 1235", interrupt, data_in); end
        drive_cycle(0, 0, 0, 1, 0, 0, 0);
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL int_ack_drop: got %b exp 0", interrupt); end
        drive_cycle(0, 0, 0, 1, 0, 0, 0);
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL service_ack: got %b exp 0", interrupt); end
        drive_cycle(0, 0, 1, 0, 0, 0, 0);
        checks++; if (interrupt !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL holdoff_entry: int=%b count=%0d exp 0 0", interrupt, fifo_count); end
        for (int k = 1; k <= 5; k++) begin
            drive_cycle(k == 1, 16'h5678, 0, 0, 0, 0, 0);
            checks++; if (interrupt !== (k == 5)) begin errors++; $display("FAIL holdoff_cyc%0d: got %b exp %b", k, interrupt, k == 5); end
        end
    endtask

    task automatic test_watermark();
        do_reset();
        for (int k = 0; k < 17; k++) begin
            drive_cycle(k < 3, 16'hC000 + 16'(k), 0, 0, 0, 0, 0);
            checks++; if (interrupt !== (k == 16)) begin errors++; $display("FAIL age_cyc%0d: got %b exp %b", k, interrupt, k == 16); end
        end
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_cycle(k < 4, 16'hD000 + 16'(k), 0, 0, 0, 0, 0);
            checks++; if (interrupt !== (k == 4)) begin errors++; $display("FAIL wm_cyc%0d: got %b exp %b", k, interrupt, k == 4); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1, 16'($urandom), 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1, 16'($urandom), 1, 0, 0, 0, 0);
            checks++; if (fifo_count !== 4'd3 || data_in !== head()) begin errors++; $display("FAIL wrap%0d: count=%0d head=%h exp 3 %h", i, fifo_count, data_in, head()); end
        end
        while (q.size() > 0) begin
            checks++; if (data_in !== head()) begin errors++; $display("FAIL wrap_drain: got %h exp %h", data_in, head()); end
            drive_cycle(0, 0, 1, 0, 0, 0, 0);
        end
        drive_cycle(1, 16'h7E57, 1, 0, 0, 0, 0);
        checks++; if (fifo_count !== 4'd1 || data_in !== 16'h7E57) begin errors++; $display("FAIL empty_push_pop: count=%0d head=%h exp 1 7E57", fifo_count, data_in); end
    endtask

    task automatic test_output();
        do_reset();
        drive_cycle(0, 0, 0, 0, 1, 16'hBEEF, 0);
        checks++; if (ext_out_valid !== 1'b1 || ext_out_data !== 16'hBEEF) begin errors++; $display("FAIL out_load: valid=%b data=%h exp 1 BEEF", ext_out_valid, ext_out_data); end
        drive_cycle(0, 0, 0, 0, 1, 16'hCAFE, 0);
        checks++; if (ext_out_data !== 16'hBEEF || out_overrun !== 1'b1) begin errors++; $display("FAIL out_drop: data=%h ovr=%b exp BEEF 1", ext_out_data, out_overrun); end
        drive_cycle(0, 0, 0, 0, 0, 0, 1);
        checks++; if (ext_out_valid !== 1'b0 || out_overrun !== 1'b1) begin errors++; $display("FAIL out_xfer: valid=%b ovr=%b exp 0 1", ext_out_valid, out_overrun); end
        drive_cycle(0, 0, 0, 0, 1, 16'h1111, 0);
        drive_cycle(0, 0, 0, 0, 1, 16'h2222, 1);
        checks++; if (ext_out_valid !== 1'b1 || ext_out_data !== 16'h2222) begin errors++; $display("FAIL out_b2b: valid=%b data=%h exp 1 2222", ext_out_valid, ext_out_data); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'($urandom), 16'($urandom), 1'($urandom), 0,
                        $urandom_range(0, 3) == 0, 16'($urandom), 1'($urandom));
            checks++;
            if (fifo_count !== 4'(q.size()) || data_in !== head() || ext_in_ready !== (q.size() < 8)
                || ext_out_valid !== m_ov || ext_out_data !== m_od || out_overrun !== m_oo) begin
                errors++;
                $display("FAIL random%0d: count=%0d/%0d head=%h/%h ready=%b valid=%b/%b data=%h/%h ovr=%b/%b",
                         i, fifo_count, q.size(), data_in, head(), ext_in_ready, ext_out_valid, m_ov,
                         ext_out_data, m_od, out_overrun, m_oo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
`ifdef IOR_WATERMARK_EN
        test_watermark();
`else
        test_interrupt();
`endif
        test_wrap();
        test_output();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
